// File: rtl/ftoi_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ftoi_pipe
//  Brief    : Pipelined IEEE-754 binary32 to signed W-bit integer converter
//             with selectable rounding, saturation and exception flags.
//  Revision : 1.0  initial release
// ============================================================================
module ftoi_pipe #(
    parameter int W      = 32,
    parameter int NSTAGE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  x,
    input  logic [1:0]   rm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf,
    output logic         nv,
    output logic         nx
);

    localparam logic [1:0]   c_rm_near  = 2'b00;
    localparam logic [1:0]   c_rm_trunc = 2'b01;
    localparam logic [1:0]   c_rm_floor = 2'b10;
    localparam logic [1:0]   c_rm_ceil  = 2'b11;
    localparam logic [32:0]  c_pos_lim  = (33'd1 << (W - 1)) - 33'd1;
    localparam logic [32:0]  c_neg_lim  = 33'd1 << (W - 1);
    localparam logic [W-1:0] c_pos_sat  = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] c_neg_sat  = {1'b1, {(W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic        w_exp_max;
    logic        w_is_nan;
    logic        w_is_inf;
    logic        w_huge;
    logic [23:0] w_sig;
    logic [7:0]  w_exp_eff;

    assign w_sign    = x[31];
    assign w_exp     = x[30:23];
    assign w_man     = x[22:0];
    assign w_exp_max = &w_exp;
    assign w_is_nan  = w_exp_max && (|w_man);
    assign w_is_inf  = w_exp_max && !(|w_man);
    // 2^32 or more cannot fit any legal width, so the shifter never sees it
    assign w_huge    = (w_exp >= 8'd159);
    assign w_sig     = {|w_exp, w_man};
    assign w_exp_eff = (w_exp == 8'd0) ? 8'd1 : w_exp;

    // ------------------------------------------------------------------
    // Alignment: value = sig * 2^(exp_eff - 150)
    // ------------------------------------------------------------------
    logic        w_left;
    logic [7:0]  w_lsh;
    logic [7:0]  w_rsh_raw;
    logic [4:0]  w_rsh;
    logic [32:0] w_lmag;
    logic [48:0] w_rt;
    logic [32:0] w_int;
    logic        w_half;
    logic        w_sticky;
    logic        w_inexact;

    assign w_left    = (w_exp_eff >= 8'd150);
    assign w_lsh     = w_exp_eff - 8'd150;
    assign w_rsh_raw = 8'd150 - w_exp_eff;
    // Beyond 25 places every significand bit sits below the half point
    assign w_rsh     = (w_rsh_raw > 8'd25) ? 5'd25 : w_rsh_raw[4:0];
    assign w_lmag    = {9'd0, w_sig} << w_lsh;
    assign w_rt      = {w_sig, 25'd0} >> w_rsh;
    assign w_int     = w_left ? w_lmag : {9'd0, w_rt[48:25]};
    assign w_half    = !w_left && w_rt[24];
    assign w_sticky  = !w_left && (|w_rt[23:0]);
    assign w_inexact = w_half || w_sticky;

    // ------------------------------------------------------------------
    // Rounding on the magnitude
    // ------------------------------------------------------------------
    logic        w_inc;
    logic [32:0] w_mag;
    logic        w_fits;
    logic [W-1:0] w_y_exact;

    always_comb begin
        w_inc = 1'b0;
        case (rm)
            c_rm_near:  w_inc = w_half;
            c_rm_trunc: w_inc = 1'b0;
            c_rm_floor: w_inc = w_sign && w_inexact;
            c_rm_ceil:  w_inc = !w_sign && w_inexact;
            default:    w_inc = 1'b0;
        endcase
    end

    assign w_mag     = w_int + {32'd0, w_inc};
    assign w_fits    = w_sign ? (w_mag <= c_neg_lim) : (w_mag <= c_pos_lim);
    assign w_y_exact = w_sign ? (-w_mag[W-1:0]) : w_mag[W-1:0];

    // ------------------------------------------------------------------
    // Result select; flags packed as {ovf, nv, nx}
    // ------------------------------------------------------------------
    logic [W-1:0] w_y;
    logic [2:0]   w_flg;

    always_comb begin
        w_y   = w_y_exact;
        w_flg = {2'b00, w_inexact};
        if (w_is_nan) begin
            w_y   = c_pos_sat;
            w_flg = 3'b010;
        end else if (w_is_inf || w_huge || !w_fits) begin
            w_y   = w_sign ? c_neg_sat : c_pos_sat;
            w_flg = 3'b100;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: the whole chain freezes while the output is blocked
    // ------------------------------------------------------------------
    logic [NSTAGE-1:0] r_vld;
    logic [W-1:0]      r_y   [NSTAGE];
    logic [2:0]        r_flg [NSTAGE];
    logic              w_adv;

    assign w_adv    = !(r_vld[NSTAGE-1] && !out_ready);
    assign in_ready = w_adv && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                r_y[i]   <= '0;
                r_flg[i] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_y[0]   <= w_y;
            r_flg[0] <= w_flg;
            for (int i = 1; i < NSTAGE; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_y[i]   <= r_y[i-1];
                r_flg[i] <= r_flg[i-1];
            end
        end
    end

    assign out_valid       = r_vld[NSTAGE-1];
    assign y               = r_y[NSTAGE-1];
    assign {ovf, nv, nx}   = r_flg[NSTAGE-1];

endmodule
`default_nettype wire
